// File: rtl/mem_copy_engine.sv
// Block COPY/FILL engine driving the 256x44 single-port data memory.
// One start pulse runs a whole job; busy/done/words_done report progress.
module mem_copy_engine #(
  parameter int DATA_W = 44,
  parameter int ADDR_W = 44,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  src,
  input  logic [IDX_W-1:0]  dst,
  input  logic [IDX_W:0]    len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    words_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic [IDX_W:0]      len_q, len_d;
  logic [IDX_W:0]      i_q, i_d;
  logic [IDX_W:0]      wd_q, wd_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   in_q, in_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    wd_d    = wd_q;
    fill_d  = fill_q;
    buf_d   = buf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          src_d  = src;
          dst_d  = dst;
          len_d  = len;
          fill_d = fill_val;
          i_d    = '0;
          wd_d   = '0;
          if (len == '0)
            state_d = DONE;
          else if (mode)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        buf_d   = mem_out;
        state_d = WR;
      end
      WR: begin
        i_d  = i_q + (IDX_W+1)'(1);
        wd_d = wd_q + (IDX_W+1)'(1);
        if (i_d == len_q)
          state_d = DONE;
        else if (mode_q)
          state_d = WR;
        else
          state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the next state.
    busy_d = (state_d == RD) || (state_d == WR);
    done_d = (state_d == DONE);
    we_d   = (state_d == WR);
    addr_d = '0;
    in_d   = '0;
    if (state_d == RD)
      addr_d = src_d + i_d[IDX_W-1:0];
    if (state_d == WR) begin
      addr_d = dst_d + i_d[IDX_W-1:0];
      in_d   = mode_d ? fill_d : buf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      wd_q    <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      wd_q    <= wd_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      in_q    <= in_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = wd_q;
  assign mem_addr   = {{(ADDR_W-IDX_W){1'b0}}, addr_q};
  assign mem_in     = in_q;
  // A reset arriving mid-write must not reach the memory.
  assign mem_we     = we_q & ~rst;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a behavioural memory
// and a word-level reference model of COPY/FILL jobs.
module tb_mem_copy_engine;
  localparam int DW = 44;
  localparam int AW = 44;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [IW-1:0] src;
  logic [IW-1:0] dst;
  logic [IW:0]   len;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic [IW:0]   words_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic          mem_we;
  logic [DW-1:0] mem_out;

  mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic          ld_en = 1'b0;
  logic [7:0]    ld_a;
  logic [DW-1:0] ld_d;

  assign mem_out = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int c; int w; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int busy_lo = -1;
  int busy_hi = -2;

  // Monitor: pops expected writes and done pulses as the DUT shows them.
  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy,
                 (cyc >= busy_lo && cyc <= busy_hi));
      end
    end
    if (mem_we) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cyc=%0d addr=%h data=%h",
                 cyc, mem_addr, mem_in);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (mem_addr !== AW'(e.a) || mem_in !== e.d) begin
          n_fail++;
          $display("FAIL write cyc=%0d got=%h/%h want=%h/%h",
                   cyc, mem_addr, mem_in, AW'(e.a), e.d);
        end
      end
    end
    if (done) begin
      n_chk++;
      n_done++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        dn_t e;
        e = dq.pop_front();
        if (cyc != e.c || words_done !== e.w[IW:0]) begin
          n_fail++;
          $display("FAIL done cyc=%0d wd=%0d want cyc=%0d wd=%0d",
                   cyc, words_done, e.c, e.w);
        end
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
    ld_a = a;
    ld_d = d;
    ld_en = 1'b1;
    ref_mem[a] = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    n_chk++;
    if ({busy, done, words_done, mem_addr, mem_in, mem_we} !== '0) begin
      n_fail++;
      $display("FAIL %s got b=%b d=%b wd=%0d a=%h in=%h we=%b want all 0",
               nm, busy, done, words_done, mem_addr, mem_in, mem_we);
    end
  endtask

  task automatic chk_image(input string nm);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== ref_mem[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s image: %0d bad words, first idx=%0d got=%h want=%h",
               nm, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  task automatic run_job(input string nm, input bit md,
                         input logic [7:0] s, input logic [7:0] d,
                         input int n, input logic [DW-1:0] fv,
                         input int rst_at, input bit repulse);
    int sc;
    int dur;
    int nw;
    int tgt;
    wr_t w;
    dn_t e;
    @(negedge clk);
    mode = md;
    src = s;
    dst = d;
    len = 9'(n);
    fill_val = fv;
    start = 1'b1;
    sc = cyc;
    tgt = n_done + 1;
    dur = (n == 0) ? 1 : (md ? n + 1 : 2 * n + 1);
    nw = n;
    if (rst_at > 0) begin
      nw = md ? rst_at - 1 : (rst_at - 1) / 2;
      if (nw > n) nw = n;
    end
    for (int k = 0; k < nw; k++) begin
      w.a = d + 8'(k);
      w.d = md ? fv : ref_mem[8'(s + 8'(k))];
      ref_mem[w.a] = w.d;
      wq.push_back(w);
    end
    busy_lo = sc + 1;
    if (rst_at > 0) begin
      busy_hi = sc + rst_at;
    end else begin
      busy_hi = sc + dur - 1;
      e.c = sc + dur;
      e.w = n;
      dq.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 1'($urandom);
    src = 8'($urandom);
    dst = 8'($urandom);
    len = 9'($urandom_range(1, 256));
    fill_val = DW'({$urandom, $urandom});
    if (repulse) begin
      @(negedge clk);
      start = 1'b1;
      dst = d + 8'h40;
      repeat (dur) @(posedge clk);
      #1 start = 1'b0;
    end
    if (rst_at > 0) begin
      repeat (rst_at - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle({nm, "_after_rst"});
      repeat (3) @(posedge clk);
    end else begin
      for (int k = 0; k < dur + 20 && n_done < tgt; k++)
        @(posedge clk);
      n_chk++;
      if (n_done < tgt) begin
        n_fail++;
        $display("FAIL %s done_timeout got=%0d want=%0d", nm, n_done, tgt);
      end
    end
    @(negedge clk);
    n_chk++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_writes got=%0d want=0", nm, wq.size());
      wq.delete();
    end
    dq.delete();
    chk_image(nm);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill_val = '0;
    for (int k = 0; k < 256; k++)
      poke(8'(k), DW'({$urandom, $urandom}));
    poke(8'h10, 44'hA_AAAA_0000A);
    poke(8'h11, 44'hB_BBBB_0000B);
    poke(8'h12, 44'hC_CCCC_0000C);
    @(negedge clk);
    chk_idle("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("idle_after_reset");
    chk_image("preload");

    run_job("copy3", 1'b0, 8'h10, 8'h20, 3, '0, 0, 1'b0);
    run_job("fill_wrap", 1'b1, 8'h00, 8'hFE, 4, 44'h123, 0, 1'b0);
    run_job("len0", 1'b0, 8'h33, 8'h44, 0, '0, 0, 1'b0);
    run_job("repulse", 1'b0, 8'h50, 8'h60, 2, '0, 0, 1'b1);
    run_job("rst_rd", 1'b0, 8'h00, 8'h08, 4, '0, 3, 1'b0);
    run_job("rst_wr", 1'b0, 8'h30, 8'h70, 4, '0, 4, 1'b0);
    run_job("rst_fill", 1'b1, 8'h00, 8'h90, 5, 44'hF0F, 3, 1'b0);
    run_job("fill256", 1'b1, 8'h00, 8'h00, 256, 44'hABC_DEF0_1234, 0, 1'b0);
    for (int k = 0; k < 256; k++)
      poke(8'(k), DW'({$urandom, $urandom}));
    run_job("overlap", 1'b0, 8'h20, 8'h22, 6, '0, 0, 1'b0);
    run_job("copy256", 1'b0, 8'h80, 8'h05, 256, '0, 0, 1'b0);
    for (int t = 0; t < 16; t++)
      run_job("rand", 1'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 40), DW'({$urandom, $urandom}), 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
